instr_fetch_unit: RTL and testbench

Instruction fetch stage for the RV32I pipeline. It owns the PC, issues word reads to the instruction memory/cache port, buffers returned instruction words in a small FIFO, and presents them with their PCs to the decode stage, which turns them into the control word. Branch and jump redirects from execute flush the buffer and cancel any outstanding fetch.

---
 rtl/instr_fetch_unit.sv | 171 +++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// RV32I instruction fetch: owns the PC, keeps one word read outstanding and
// buffers returned words with their PCs in a small FIFO for decode.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0060,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_read,
  output logic [31:0] imem_address,
  input  logic [31:0] imem_rdata,
  input  logic        imem_resp,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] WAIT    = 2'd1;
  localparam logic [1:0] DISCARD = 2'd2;

  logic [1:0]    state_r, state_s;
  logic [31:0]   pc_r, pc_s;
  logic          read_r, read_s;
  logic [31:0]   addr_r, addr_s;
  logic [CW-1:0] count_r, count_s;
  logic          valid_r;
  logic [AW-1:0] wr_ptr_r, rd_ptr_r;
  logic [31:0]   data_mem_r [DEPTH];
  logic [31:0]   pc_mem_r   [DEPTH];

  logic          push_s, pop_s;
  logic [31:0]   target_s, pc_inc_s;

  assign target_s = redirect_pc & 32'hFFFF_FFFC;
  assign pc_inc_s = pc_r + 32'd4;
  // A redirect kills both the word arriving this cycle and any pop.
  assign push_s   = (state_r == WAIT) & imem_resp & ~redirect_valid;
  assign pop_s    = valid_r & ~stall & ~redirect_valid;

  // Occupancy after this cycle's flush / push / pop.
  always_comb begin
    count_s = count_r;
    if (redirect_valid) begin
      count_s = {CW{1'b0}};
    end else if (push_s && !pop_s) begin
      count_s = count_r + CW'(1);
    end else if (pop_s && !push_s) begin
      count_s = count_r - CW'(1);
    end else begin
      count_s = count_r;
    end
  end

  // Fetch FSM: request issue, response acceptance and redirect handling.
  always_comb begin
    state_s = state_r;
    pc_s    = pc_r;
    read_s  = read_r;
    addr_s  = addr_r;
    case (state_r)
      IDLE: begin
        if (redirect_valid) begin
          pc_s = target_s;
        end else if (count_r < FULL_C) begin
          state_s = WAIT;
          read_s  = 1'b1;
          addr_s  = pc_r;
        end else begin
          state_s = IDLE;
        end
      end
      WAIT: begin
        if (imem_resp && redirect_valid) begin
          state_s = IDLE;
          read_s  = 1'b0;
          pc_s    = target_s;
        end else if (imem_resp) begin
          pc_s = pc_inc_s;
          if (count_s < FULL_C) begin
            read_s = 1'b1;
            addr_s = pc_inc_s;
          end else begin
            state_s = IDLE;
            read_s  = 1'b0;
          end
        end else if (redirect_valid) begin
          // Address stays put until the in-flight read completes.
          state_s = DISCARD;
          pc_s    = target_s;
        end else begin
          state_s = WAIT;
        end
      end
      DISCARD: begin
        if (redirect_valid) begin
          pc_s = target_s;
        end else begin
          pc_s = pc_r;
        end
        if (imem_resp) begin
          state_s = IDLE;
          read_s  = 1'b0;
        end else begin
          state_s = DISCARD;
        end
      end
      default: begin
        state_s = IDLE;
        read_s  = 1'b0;
      end
    endcase
  end

  // Control and memory-request registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      pc_r    <= RESET_PC;
      read_r  <= 1'b0;
      addr_r  <= 32'd0;
      count_r <= {CW{1'b0}};
      valid_r <= 1'b0;
    end else begin
      state_r <= state_s;
      pc_r    <= pc_s;
      read_r  <= read_s;
      addr_r  <= addr_s;
      count_r <= count_s;
      valid_r <= (count_s != {CW{1'b0}});
    end
  end

  // Instruction FIFO storage and pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        data_mem_r[i] <= 32'd0;
        pc_mem_r[i]   <= 32'd0;
      end
    end else if (redirect_valid) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
    end else begin
      if (push_s) begin
        data_mem_r[wr_ptr_r] <= imem_rdata;
        pc_mem_r[wr_ptr_r]   <= pc_r;
        wr_ptr_r             <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
    end
  end

  assign imem_read    = read_r;
  assign imem_address = addr_r;
  assign instr_valid  = valid_r;
  assign instr        = data_mem_r[rd_ptr_r];
  assign instr_pc     = pc_mem_r[rd_ptr_r];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a memory model with programmable
// latency plus a scoreboard of expected {pc, word} entries.
module tb_instr_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0060;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } ent_t;

  logic        clk;
  logic        rst_n;
  logic        imem_read;
  logic [31:0] imem_address;
  logic [31:0] imem_rdata;
  logic        imem_resp;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  instr_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_read      (imem_read),
    .imem_address   (imem_address),
    .imem_rdata     (imem_rdata),
    .imem_resp      (imem_resp),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  ent_t        q[$];
  logic [31:0] pop_log[$];
  logic [31:0] req_log[$];
  logic        outstanding = 1'b0;
  logic        cancelled = 1'b0;
  logic [31:0] rec_addr = 32'd0;
  logic [31:0] model_pc = RESET_PC;
  int          cnt = 0;
  int          lat = 1;
  int          nresp = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] plog(input int i);
    return (i < pop_log.size()) ? pop_log[i] : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] rlog(input int i);
    return (i < req_log.size()) ? req_log[i] : 32'hFFFF_FFFF;
  endfunction

  // One cycle: check outputs at negedge, run memory model, drive inputs.
  task automatic step(input logic st, input logic rv, input logic [31:0] rp);
    ent_t        e;
    logic        resp;
    logic        justrec;
    logic [31:0] rd;
    @(negedge clk);
    chk("valid", 32'(instr_valid), 32'(q.size() != 0));
    if (q.size() != 0 && instr_valid) begin
      chk("head_pc", instr_pc, q[0].pc);
      chk("head_instr", instr, q[0].data);
      if (!st && !rv) begin
        e = q.pop_front();
        pop_log.push_back(e.pc);
      end
    end
    justrec = 1'b0;
    resp    = 1'b0;
    rd      = 32'd0;
    if (!outstanding && imem_read) begin
      chk("req_addr", imem_address, model_pc);
      rec_addr    = model_pc;
      req_log.push_back(model_pc);
      cnt         = lat;
      cancelled   = 1'b0;
      outstanding = 1'b1;
      justrec     = 1'b1;
    end else if (outstanding) begin
      chk("hold_read", 32'(imem_read), 32'd1);
      chk("hold_addr", imem_address, rec_addr);
      cnt--;
    end
    if (rv && outstanding) cancelled = 1'b1;
    if (outstanding && !justrec && cnt == 0) begin
      resp = 1'b1;
      rd   = rec_addr ^ 32'hA5A5_0000;
      if (!cancelled) begin
        e.pc   = rec_addr;
        e.data = rd;
        q.push_back(e);
        model_pc = rec_addr + 32'd4;
        nresp++;
      end
      outstanding = 1'b0;
    end
    if (rv) begin
      q.delete();
      model_pc = rp & 32'hFFFF_FFFC;
    end
    stall          = st;
    redirect_valid = rv;
    redirect_pc    = rp;
    imem_resp      = resp;
    imem_rdata     = resp ? rd : $urandom();
  endtask

  task automatic run_until_req(input int need);
    for (int i = 0; i < 60; i++) begin
      if (req_log.size() >= need) break;
      step(1'b0, 1'b0, 32'd0);
    end
    chk("wait_req", 32'(req_log.size() >= need), 32'd1);
  endtask

  task automatic do_reset(input logic st);
    rst_n          = 1'b0;
    imem_resp      = 1'b0;
    imem_rdata     = 32'd0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    stall          = st;
    q.delete();
    outstanding    = 1'b0;
    cancelled      = 1'b0;
    cnt            = 0;
    model_pc       = RESET_PC;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_read"},  32'(imem_read),   32'd0);
    chk({tag, "_addr"},  imem_address,     32'd0);
    chk({tag, "_valid"}, 32'(instr_valid), 32'd0);
    chk({tag, "_instr"}, instr,            32'd0);
    chk({tag, "_pc"},    instr_pc,         32'd0);
  endtask

  initial begin
    rst_n          = 1'b0;
    stall          = 1'b0;
    imem_resp      = 1'b0;
    imem_rdata     = 32'd0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    @(negedge clk);
    chk_reset_outputs("rst");

    // Reset release and back-to-back stream.
    lat = 1;
    do_reset(1'b0);
    @(posedge clk);
    #1;
    chk("first_read", 32'(imem_read), 32'd1);
    chk("first_addr", imem_address, RESET_PC);
    nresp = 0;
    pop_log.delete();
    repeat (20) step(1'b0, 1'b0, 32'd0);
    chk("stream_resps", 32'(nresp), 32'd10);
    chk("stream_pop0", plog(0), 32'h60);
    chk("stream_pop1", plog(1), 32'h64);
    chk("stream_pop2", plog(2), 32'h68);

    // Backpressure from reset.
    do_reset(1'b1);
    repeat (10) step(1'b1, 1'b0, 32'd0);
    chk("bp_read", 32'(imem_read), 32'd0);
    chk("bp_valid", 32'(instr_valid), 32'd1);
    chk("bp_head", instr_pc, 32'h60);
    chk("bp_count", 32'(q.size()), 32'd2);
    pop_log.delete();
    repeat (10) step(1'b0, 1'b0, 32'd0);
    chk("bp_pop0", plog(0), 32'h60);
    chk("bp_pop1", plog(1), 32'h64);
    chk("bp_pop2", plog(2), 32'h68);

    // Redirect in the second wait cycle of a slow read.
    lat = 5;
    req_log.delete();
    run_until_req(1);
    step(1'b0, 1'b1, 32'h0000_0200);
    pop_log.delete();
    req_log.delete();
    repeat (20) step(1'b0, 1'b0, 32'd0);
    chk("rw_next_req", rlog(0), 32'h200);
    chk("rw_first_pop", plog(0), 32'h200);

    // Redirect coinciding with the response.
    lat = 1;
    req_log.delete();
    run_until_req(1);
    step(1'b0, 1'b1, 32'h0000_1003);
    chk("sim_valid_now", 32'(q.size()), 32'd0);
    req_log.delete();
    run_until_req(1);
    chk("sim_next_req", rlog(0), 32'h1000);

    // PC wrap-around.
    req_log.delete();
    step(1'b0, 1'b1, 32'hFFFF_FFFC);
    run_until_req(2);
    chk("wrap_req0", rlog(0), 32'hFFFF_FFFC);
    chk("wrap_req1", rlog(1), 32'h0000_0000);

    // Asynchronous reset in the middle of a request.
    req_log.delete();
    run_until_req(1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async");
    do_reset(1'b0);
    req_log.delete();
    run_until_req(1);
    chk("restart_req", rlog(0), RESET_PC);
    repeat (4) step(1'b0, 1'b0, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
